// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO write-side blocks.
package fifo_pkg;

    typedef enum logic [1:0] {
        SK_EMPTY = 2'd0,
        SK_ONE   = 2'd1,
        SK_TWO   = 2'd2
    } skid_state_t;

    // Gray-to-binary over the low 'width' bits; upper bits are masked off first.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int unsigned width);
        logic [31:0] g;
        logic [31:0] bin;
        logic        acc;
        g   = (width >= 32) ? gray : (gray & ((32'd1 << width) - 32'd1));
        bin = '0;
        acc = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            acc    = acc ^ g[i];
            bin[i] = acc;
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
module gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    assign bin = W'(fifo_pkg::gray2bin(32'(gray), W));

endmodule

// File: rtl/wr_stream_ctrl.sv
// Write-side front end of the async FIFO: 2-entry skid buffer feeding winc/wdata,
// plus registered fill level and almost-full derived from the Gray pointers.
module wr_stream_ctrl
    import fifo_pkg::*;
#(
    parameter int DSIZE        = 8,
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 2**ADDRSIZE - 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DSIZE-1:0]    s_data,
    input  logic                wfull,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic                winc,
    output logic [DSIZE-1:0]    wdata,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wafull,
    output skid_state_t         skid_state
);

    localparam logic [ADDRSIZE:0] THRESH = (ADDRSIZE+1)'(AFULL_THRESH);

    // Handshake: a word moves from upstream on a rising edge where s_valid and
    // s_ready are both 1; upstream holds s_data steady while s_valid=1 and s_ready=0.
    // The FIFO takes head on every edge where winc=1.

    skid_state_t       state;
    logic [DSIZE-1:0]  head;
    logic [DSIZE-1:0]  tail;
    logic              push;
    logic              pop;
    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] lvl;

    assign push       = s_valid & s_ready;
    assign pop        = (state != SK_EMPTY) & ~wfull;
    assign winc       = pop;
    assign wdata      = head;
    assign skid_state = state;

    gray2bin #(.W(ADDRSIZE+1)) u_wbin (.gray(wptr),     .bin(wbin));
    gray2bin #(.W(ADDRSIZE+1)) u_rbin (.gray(wq2_rptr), .bin(rbin));

    // Modular subtraction handles pointer wrap; no clamping, corruption shows as > depth.
    assign lvl = wbin - rbin;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state   <= SK_EMPTY;
            s_ready <= 1'b0;
            wlevel  <= '0;
            wafull  <= 1'b0;
        end else begin
            wlevel <= lvl;
            wafull <= (lvl >= THRESH);
            case (state)
                SK_EMPTY: begin
                    s_ready <= 1'b1;
                    if (push) begin
                        head  <= s_data;
                        state <= SK_ONE;
                    end
                end
                SK_ONE: begin
                    if (push && !pop) begin
                        tail    <= s_data;
                        state   <= SK_TWO;
                        s_ready <= 1'b0;
                    end else if (pop && !push) begin
                        state   <= SK_EMPTY;
                        s_ready <= 1'b1;
                    end else if (push && pop) begin
                        head    <= s_data;
                        s_ready <= 1'b1;
                    end else begin
                        s_ready <= 1'b1;
                    end
                end
                SK_TWO: begin
                    // s_ready is low here, so only a pop can happen.
                    if (pop) begin
                        head    <= tail;
                        state   <= SK_ONE;
                        s_ready <= 1'b1;
                    end else begin
                        s_ready <= 1'b0;
                    end
                end
                default: begin
                    state   <= SK_EMPTY;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wr_stream_ctrl.sv
// Directed bench for wr_stream_ctrl: reset, streaming, stall, level/almost-full, reset mid-fill.
module tb_wr_stream_ctrl;
    import fifo_pkg::*;

    logic        wclk = 1'b0;
    logic        wrst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        wfull = 1'b0;
    logic [4:0]  wptr = 5'd0;
    logic [4:0]  wq2_rptr = 5'd0;
    logic        winc;
    logic [7:0]  wdata;
    logic [4:0]  wlevel;
    logic        wafull;
    skid_state_t skid_state;

    wr_stream_ctrl #(.DSIZE(8), .ADDRSIZE(4), .AFULL_THRESH(14)) dut (
        .wclk(wclk), .wrst(wrst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .wfull(wfull), .wptr(wptr), .wq2_rptr(wq2_rptr), .winc(winc), .wdata(wdata),
        .wlevel(wlevel), .wafull(wafull), .skid_state(skid_state)
    );

    // Clock/reset
    always #5 wclk = ~wclk;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] src_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         got_idx_q[$];
    logic       rdy_prev = 1'b0;
    logic       rst_prev = 1'b1;
    int         step_no = 0;
    logic [4:0] wbin = 5'd0;

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    always @(negedge wclk) begin
        if (!wrst) assert (wlevel <= 5'd16) else $error("wlevel %0d exceeds depth", wlevel);
    end

    // Driver: one cycle of upstream source, FIFO full flag and pointer model.
    task automatic step(input logic full, input logic rst);
        @(negedge wclk);
        if (s_valid && rdy_prev && !rst_prev && src_q.size() > 0) void'(src_q.pop_front());
        wfull    = full;
        wrst     = rst;
        rst_prev = rst;
        if (src_q.size() > 0) begin
            s_valid = 1'b1;
            s_data  = src_q[0];
        end else begin
            s_valid = 1'b0;
        end
        #1;
        if (winc) begin
            got_q.push_back(wdata);
            got_idx_q.push_back(step_no);
            wbin     = wbin + 5'd1;
            wptr     = to_gray(wbin);
            wq2_rptr = to_gray(wbin);
        end
        rdy_prev = s_ready;
        step_no++;
    endtask

    task automatic set_ptrs(input logic [4:0] wb, input logic [4:0] rb);
        @(negedge wclk);
        wptr     = to_gray(wb);
        wq2_rptr = to_gray(rb);
        wbin     = wb;
        #1;
        rdy_prev = s_ready;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
        checks++; if (winc !== 1'b0) begin failures++; $display("FAIL reset_winc got=%b exp=0", winc); end
        checks++; if (wlevel !== 5'd0) begin failures++; $display("FAIL reset_wlevel got=%0d exp=0", wlevel); end
        checks++; if (wafull !== 1'b0) begin failures++; $display("FAIL reset_wafull got=%b exp=0", wafull); end
        checks++; if (skid_state !== SK_EMPTY) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", skid_state, SK_EMPTY); end
        step(1'b0, 1'b0);
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_held got=%b exp=0", s_ready); end
        step(1'b0, 1'b0);
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_rise got=%b exp=1", s_ready); end
        checks++; if (winc !== 1'b0) begin failures++; $display("FAIL idle_winc got=%b exp=0", winc); end
    endtask

    task automatic test_stream();
        int start;
        got_q.delete(); got_idx_q.delete(); exp_q.delete();
        for (int i = 1; i <= 16; i++) begin
            src_q.push_back(8'(i));
            exp_q.push_back(8'(i));
        end
        start = step_no;
        for (int c = 0; c < 40 && got_q.size() < 16; c++) step(1'b0, 1'b0);
        checks++; if (got_q.size() != 16) begin failures++; $display("FAIL stream_count got=%0d exp=16", got_q.size()); end
        if (got_q.size() == 16) begin
            checks++; if (got_idx_q[0] - start != 1) begin failures++; $display("FAIL stream_latency got=%0d exp=1", got_idx_q[0] - start); end
            checks++; if (got_idx_q[15] - got_idx_q[0] != 15) begin failures++; $display("FAIL stream_gaps span=%0d exp=15", got_idx_q[15] - got_idx_q[0]); end
            for (int i = 0; i < 16; i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL stream_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
            end
        end
        step(1'b0, 1'b0);
        checks++; if (skid_state !== SK_EMPTY) begin failures++; $display("FAIL stream_drained got=%0d exp=%0d", skid_state, SK_EMPTY); end
    endtask

    task automatic test_stall();
        got_q.delete(); got_idx_q.delete(); exp_q.delete();
        src_q.push_back(8'hA0); src_q.push_back(8'hA1); src_q.push_back(8'hA2);
        exp_q.push_back(8'hA0); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b exp=0", s_ready); end
        checks++; if (skid_state !== SK_TWO) begin failures++; $display("FAIL stall_state got=%0d exp=%0d", skid_state, SK_TWO); end
        checks++; if (winc !== 1'b0) begin failures++; $display("FAIL stall_winc got=%b exp=0", winc); end
        step(1'b1, 1'b0);
        checks++; if (src_q.size() != 1) begin failures++; $display("FAIL stall_held_upstream got=%0d exp=1", src_q.size()); end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL stall_no_write got=%0d exp=0", got_q.size()); end
        for (int c = 0; c < 10 && got_q.size() < 3; c++) step(1'b0, 1'b0);
        checks++; if (got_q.size() != 3) begin failures++; $display("FAIL stall_count got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_level();
        set_ptrs(5'd13, 5'd0);
        set_ptrs(5'd14, 5'd0);
        checks++; if (wlevel !== 5'd13) begin failures++; $display("FAIL level13 got=%0d exp=13", wlevel); end
        checks++; if (wafull !== 1'b0) begin failures++; $display("FAIL afull13 got=%b exp=0", wafull); end
        set_ptrs(5'd2, 5'd30);
        checks++; if (wlevel !== 5'd14) begin failures++; $display("FAIL level14 got=%0d exp=14", wlevel); end
        checks++; if (wafull !== 1'b1) begin failures++; $display("FAIL afull14 got=%b exp=1", wafull); end
        set_ptrs(5'd9, 5'd9);
        checks++; if (wlevel !== 5'd4) begin failures++; $display("FAIL level_wrap got=%0d exp=4", wlevel); end
        checks++; if (wafull !== 1'b0) begin failures++; $display("FAIL afull_wrap got=%b exp=0", wafull); end
        set_ptrs(5'd16, 5'd0);
        checks++; if (wlevel !== 5'd0) begin failures++; $display("FAIL level_equal got=%0d exp=0", wlevel); end
        set_ptrs(5'd3, 5'd20);
        checks++; if (wlevel !== 5'd16) begin failures++; $display("FAIL level_full got=%0d exp=16", wlevel); end
        checks++; if (wafull !== 1'b1) begin failures++; $display("FAIL afull_full got=%b exp=1", wafull); end
        set_ptrs(5'd0, 5'd0);
        checks++; if (wlevel !== 5'd15) begin failures++; $display("FAIL level_wrap15 got=%0d exp=15", wlevel); end
        checks++; if (wafull !== 1'b1) begin failures++; $display("FAIL afull_wrap15 got=%b exp=1", wafull); end
        set_ptrs(5'd0, 5'd0);
    endtask

    task automatic test_reset_mid();
        got_q.delete(); got_idx_q.delete(); exp_q.delete();
        src_q.push_back(8'hB0); src_q.push_back(8'hB1); src_q.push_back(8'hB2);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        checks++; if (skid_state !== SK_TWO) begin failures++; $display("FAIL rstmid_two got=%0d exp=%0d", skid_state, SK_TWO); end
        src_q.delete();
        src_q.push_back(8'hC0); src_q.push_back(8'hC1);
        exp_q.push_back(8'hC0); exp_q.push_back(8'hC1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        checks++; if (skid_state !== SK_EMPTY) begin failures++; $display("FAIL rstmid_state got=%0d exp=%0d", skid_state, SK_EMPTY); end
        checks++; if (winc !== 1'b0) begin failures++; $display("FAIL rstmid_winc got=%b exp=0", winc); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready_low got=%b exp=0", s_ready); end
        step(1'b0, 1'b0);
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready_rise got=%b exp=1", s_ready); end
        checks++; if (winc !== 1'b0) begin failures++; $display("FAIL rstmid_no_stale got=%b exp=0", winc); end
        for (int c = 0; c < 10 && got_q.size() < 2; c++) step(1'b0, 1'b0);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0);
        checks++; if (got_q.size() != 2) begin failures++; $display("FAIL rstmid_count got=%0d exp=2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rstmid_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_level();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
